brightness_sequencer: RTL and testbench
=======================================

Name: brightness_sequencer

Overview:
- Generates the 4-bit duty value consumed by the PWM brightness stage, whose duty is high for counts 0..level of a 16-clock period.
- Replaces the raw switch-to-duty connection with four selectable sources:
  - manual: switch level passed through;
  - breathe: triangle fade;
  - sawtooth: ramp with wrap;
  - step: debounced up/down buttons.
- Sits between board inputs (SW, BTN) and the PWM stage, all in the CLK100MHZ domain.

Parameters:
- STEP_DIV, 6250000: clocks per ramp step. Gives 16 steps/s at 100 MHz. Minimum 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable clocks (10 ms) needed before a button state is accepted. Minimum 2.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz.
- CPU_RESETN  input  1  reset, asynchronous assert, active-low.
- mode  input  2  source select: 00 manual, 01 breathe, 10 sawtooth, 11 step. Asynchronous (switches).
- manual_level  input  4  manual duty value. Asynchronous (switches).
- btn_up  input  1  raw pushbutton, active-high, asynchronous.
- btn_down  input  1  raw pushbutton, active-high, asynchronous.
- level  output  4  duty value to the PWM stage.
- level_changed  output  1  one-clock pulse in the cycle level takes a new value.
- step_tick  output  1  one-clock prescaler pulse, exported for the bench and for LEDs.

Behaviour:
- One clock, CLK100MHZ. Reset CPU_RESETN is asynchronous and active-low; all flops clear on assertion.
- Reset values:
  - level=0, level_changed=0, step_tick=0;
  - prescaler=0, state=MANUAL;
  - debouncer stable states=0, debouncer counters=0.
- Synchronisers:
  - mode, manual_level, btn_up and btn_down each pass through a 2-flop synchroniser. All logic uses only the synchronised copies.
  - Latency from a manual_level change to level is 3 clocks.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps to 0.
  - step_tick=1 in the cycle the count equals STEP_DIV-1.
  - Free-running in every mode.
- State machine, states MANUAL, BR_UP, BR_DOWN, SAW, STEP:
  - Each cycle the synchronised mode selects the target state.
  - mode 01 from a non-breathe state: enter BR_DOWN if level==15, else BR_UP.
  - Entering SAW or STEP keeps the current level. There is no reset to 0 on a mode change.
  - A mode change in the same cycle as step_tick: the new state's rule applies; the tick is not applied under the old rule.
- MANUAL: level <= synchronised manual_level every cycle.
- BR_UP, on step_tick: if level==15 then level<=14 and go to BR_DOWN; else level+1.
- BR_DOWN, on step_tick: if level==0 then level<=1 and go to BR_UP; else level-1.
- Breathe sequence is 0,1..15,14..1,0,1. Each endpoint appears once per cycle; period 30 ticks.
- SAW, on step_tick: level+1 modulo 16 (15 wraps to 0).
- STEP:
  - An up_press pulse raises level by 1, saturating at 15.
  - A down_press pulse lowers level by 1, saturating at 0.
  - Both pulses in the same cycle: no change.
  - step_tick is ignored.
- Debounce, per button:
  - The counter resets whenever the synchronised input equals the stable state.
  - Otherwise the counter increments. At DEBOUNCE_CYCLES-1 the stable state flips and the counter clears.
  - press = one-clock pulse on a 0->1 stable transition. Releases produce no pulse.
  - Debouncers always run; presses outside STEP are discarded, not queued.
- level_changed: registered alongside level; 1 only if the new level differs from the old.
- Mid-operation reset: outputs return to reset values immediately (asynchronous). The first post-reset mode is seen 2 clocks after deassertion.

Decomposition:
- Shared header/package holds:
  - mode encodings: MODE_MANUAL, MODE_BREATHE, MODE_SAW, MODE_STEP;
  - state encodings;
  - LEVEL_W=4 and LEVEL_MAX=15, also used by the PWM stage.
- One sub-module: button_debounce. It contains the synchroniser, counter, stable state and press pulse, with DEBOUNCE_CYCLES as a parameter. It is instantiated twice.

Test Plan (STEP_DIV=4, DEBOUNCE_CYCLES=3):
- Reset then mode=00, manual_level=9 -> level=9 on the 3rd clock; level_changed pulses once; level holds at 9 afterwards.
- mode=01 from level=0 -> level advances once per step_tick (every 4 clocks): 1..15, 14..0, then 1. Exactly 30 ticks per period; 15 and 0 each appear once.
- mode=10 from level=13 -> 14, 15, 0, 1 on successive ticks; level_changed asserts on every tick.
- mode=11, level=14, three clean btn_up presses -> 15, 15, 15. Then one btn_down press -> 14.
- mode=11, btn_up bounce 1,0,1,0 every clock, then a steady 1 held 3+ clocks -> exactly one increment. Simultaneous clean up and down presses -> no change.
- In mode=01, assert CPU_RESETN=0 mid-ramp -> level=0 and step_tick=0 asynchronously. After release with mode=01 held -> BR_UP from 0.

Source files
------------

// File: rtl/brightness_sequencer_pkg.sv
// ============================================================================
// Module      : brightness_sequencer_pkg
// Description : Shared mode/state encodings and level width for the
//               brightness sequencer and the downstream PWM stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package brightness_sequencer_pkg;

    localparam int                 LEVEL_W   = 4;
    localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

    typedef enum logic [1:0] {
        MODE_MANUAL  = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_SAW     = 2'b10,
        MODE_STEP    = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_MANUAL  = 3'd0,
        ST_BR_UP   = 3'd1,
        ST_BR_DOWN = 3'd2,
        ST_SAW     = 3'd3,
        ST_STEP    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchroniser, stability counter and press pulse for
//               one raw active-high pushbutton.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int               CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        press_d  = 1'b0;
        // Any sample agreeing with the accepted state restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                press_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/brightness_sequencer.sv
// ============================================================================
// Module      : brightness_sequencer
// Description : Selects the PWM duty level from manual switches, a breathing
//               triangle, a sawtooth ramp or debounced up/down buttons.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module brightness_sequencer
    import brightness_sequencer_pkg::*;
#(
    parameter int STEP_DIV        = 6250000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic               CLK100MHZ,
    input  logic               CPU_RESETN,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] manual_level,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [LEVEL_W-1:0] level,
    output logic               level_changed,
    output logic               step_tick
);

    localparam int                PRESC_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

    logic [1:0]         mode_s1_q, mode_s1_d;
    logic [1:0]         mode_s2_q, mode_s2_d;
    logic [LEVEL_W-1:0] man_s1_q, man_s1_d;
    logic [LEVEL_W-1:0] man_s2_q, man_s2_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    state_e             state_q, state_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               level_changed_q, level_changed_d;

    state_e             eff_state;
    logic               tick;
    logic               up_press;
    logic               down_press;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_up (
        .clk     (CLK100MHZ),
        .rst_n   (CPU_RESETN),
        .btn_raw (btn_up),
        .press   (up_press)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce_down (
        .clk     (CLK100MHZ),
        .rst_n   (CPU_RESETN),
        .btn_raw (btn_down),
        .press   (down_press)
    );

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        mode_s1_d = mode;
        mode_s2_d = mode_s1_q;
        man_s1_d  = manual_level;
        man_s2_d  = man_s1_q;
        presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
    end

    // The synchronised mode picks the state whose rule applies this cycle,
    // so a tick coinciding with a mode change follows the new mode.
    always_comb begin
        eff_state = ST_MANUAL;
        case (mode_s2_q)
            MODE_MANUAL:  eff_state = ST_MANUAL;
            MODE_BREATHE: begin
                if (state_q == ST_BR_UP || state_q == ST_BR_DOWN)
                    eff_state = state_q;
                else if (level_q == LEVEL_MAX)
                    eff_state = ST_BR_DOWN;
                else
                    eff_state = ST_BR_UP;
            end
            MODE_SAW:     eff_state = ST_SAW;
            default:      eff_state = ST_STEP;
        endcase
    end

    always_comb begin
        state_d = eff_state;
        level_d = level_q;
        case (eff_state)
            ST_MANUAL: level_d = man_s2_q;
            ST_BR_UP: begin
                if (tick) begin
                    if (level_q == LEVEL_MAX) begin
                        level_d = LEVEL_MAX - LEVEL_W'(1);
                        state_d = ST_BR_DOWN;
                    end else begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                end
            end
            ST_BR_DOWN: begin
                if (tick) begin
                    if (level_q == '0) begin
                        level_d = LEVEL_W'(1);
                        state_d = ST_BR_UP;
                    end else begin
                        level_d = level_q - LEVEL_W'(1);
                    end
                end
            end
            ST_SAW: begin
                if (tick)
                    level_d = level_q + LEVEL_W'(1);
            end
            ST_STEP: begin
                if (up_press && !down_press && level_q != LEVEL_MAX)
                    level_d = level_q + LEVEL_W'(1);
                else if (down_press && !up_press && level_q != '0)
                    level_d = level_q - LEVEL_W'(1);
            end
            default: state_d = ST_MANUAL;
        endcase
        level_changed_d = (level_d != level_q);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            mode_s1_q       <= 2'b00;
            mode_s2_q       <= 2'b00;
            man_s1_q        <= '0;
            man_s2_q        <= '0;
            presc_q         <= '0;
            state_q         <= ST_MANUAL;
            level_q         <= '0;
            level_changed_q <= 1'b0;
        end else begin
            mode_s1_q       <= mode_s1_d;
            mode_s2_q       <= mode_s2_d;
            man_s1_q        <= man_s1_d;
            man_s2_q        <= man_s2_d;
            presc_q         <= presc_d;
            state_q         <= state_d;
            level_q         <= level_d;
            level_changed_q <= level_changed_d;
        end
    end

    assign level         = level_q;
    assign level_changed = level_changed_q;
    assign step_tick     = tick;

endmodule

`default_nettype wire

// File: tb/tb_brightness_sequencer.sv
// ============================================================================
// Module      : tb_brightness_sequencer
// Description : Directed self-checking bench, STEP_DIV=4, DEBOUNCE_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_brightness_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] manual_level;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] level;
    logic       level_changed;
    logic       step_tick;

    int checks = 0;
    int errors = 0;

    brightness_sequencer #(
        .STEP_DIV        (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .CLK100MHZ     (clk),
        .CPU_RESETN    (rst_n),
        .mode          (mode),
        .manual_level  (manual_level),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .level         (level),
        .level_changed (level_changed),
        .step_tick     (step_tick)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; mode = 2'b00; manual_level = 4'd0; btn_up = 1'b0; btn_down = 1'b0;
        cyc(2);
        checks++;
        if (level !== 4'd0 || level_changed !== 1'b0 || step_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset: level=%0d changed=%b tick=%b, required 0/0/0", level, level_changed, step_tick);
        end
    endtask

    task automatic test_manual;
        rst_n = 1'b1; manual_level = 4'd9;
        cyc(2);
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL manual_latency2: level=%0d, required 0", level);
        end
        cyc(1);
        checks++;
        if (level !== 4'd9 || level_changed !== 1'b1) begin
            errors++;
            $display("FAIL manual_latency3: level=%0d changed=%b, required 9/1", level, level_changed);
        end
        cyc(1);
        checks++;
        if (level_changed !== 1'b0) begin
            errors++;
            $display("FAIL manual_pulse: changed=%b, required 0", level_changed);
        end
        cyc(5);
        checks++;
        if (level !== 4'd9 || level_changed !== 1'b0) begin
            errors++;
            $display("FAIL manual_hold: level=%0d changed=%b, required 9/0", level, level_changed);
        end
    endtask

    task automatic test_breathe;
        logic [3:0] exp_lvl;
        logic       t;
        int         idx;
        int         bad;
        manual_level = 4'd0;
        cyc(4);
        mode = 2'b01;
        cyc(2);
        checks++;
        if (level !== 4'd0) begin
            errors++;
            $display("FAIL breathe_start: level=%0d, required 0", level);
        end
        exp_lvl = 4'd0; idx = 1; bad = 0;
        for (int c = 0; c < 31 * 4 + 8 && idx <= 31; c++) begin
            t = step_tick;
            cyc(1);
            if (t) begin
                exp_lvl = (idx <= 15) ? 4'(idx) : ((idx <= 30) ? 4'(30 - idx) : 4'(idx - 30));
                idx++;
            end
            checks++;
            if (level !== exp_lvl || level_changed !== t) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL breathe_seq: tick#%0d level=%0d changed=%b, required %0d/%b", idx - 1, level, level_changed, exp_lvl, t);
            end
        end
        checks++;
        if (idx != 32) begin
            errors++;
            $display("FAIL breathe_ticks: ticks=%0d, required 31", idx - 1);
        end
    endtask

    task automatic test_sawtooth;
        logic [3:0] exp_seq [4];
        logic [3:0] exp_lvl;
        logic       t;
        int         idx;
        exp_seq[0] = 4'd14; exp_seq[1] = 4'd15; exp_seq[2] = 4'd0; exp_seq[3] = 4'd1;
        mode = 2'b00; manual_level = 4'd13;
        cyc(4);
        checks++;
        if (level !== 4'd13) begin
            errors++;
            $display("FAIL saw_preload: level=%0d, required 13", level);
        end
        mode = 2'b10;
        cyc(2);
        exp_lvl = 4'd13; idx = 0;
        for (int c = 0; c < 24 && idx < 4; c++) begin
            t = step_tick;
            cyc(1);
            if (t) begin
                exp_lvl = exp_seq[idx];
                idx++;
            end
            checks++;
            if (level !== exp_lvl || level_changed !== t) begin
                errors++;
                $display("FAIL saw_seq: level=%0d changed=%b, required %0d/%b", level, level_changed, exp_lvl, t);
            end
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL saw_ticks: ticks=%0d, required 4", idx);
        end
    endtask

    task automatic test_step_buttons;
        logic [3:0] exp_seq [5];
        exp_seq[0] = 4'd15; exp_seq[1] = 4'd15; exp_seq[2] = 4'd15; exp_seq[3] = 4'd14; exp_seq[4] = 4'd13;
        mode = 2'b00; manual_level = 4'd14;
        cyc(4);
        mode = 2'b11;
        cyc(2);
        checks++;
        if (level !== 4'd14) begin
            errors++;
            $display("FAIL step_entry: level=%0d, required 14", level);
        end
        for (int p = 0; p < 5; p++) begin
            if (p < 3) btn_up = 1'b1; else btn_down = 1'b1;
            cyc(8);
            btn_up = 1'b0; btn_down = 1'b0;
            cyc(8);
            checks++;
            if (level !== exp_seq[p]) begin
                errors++;
                $display("FAIL step_press%0d: level=%0d, required %0d", p, level, exp_seq[p]);
            end
        end
    endtask

    task automatic test_bounce_and_both;
        for (int b = 0; b < 4; b++) begin
            btn_up = ~b[0];
            cyc(1);
        end
        btn_up = 1'b0;
        cyc(8);
        checks++;
        if (level !== 4'd13) begin
            errors++;
            $display("FAIL bounce_only: level=%0d, required 13", level);
        end
        btn_up = 1'b1;
        cyc(8);
        btn_up = 1'b0;
        cyc(8);
        checks++;
        if (level !== 4'd14) begin
            errors++;
            $display("FAIL bounce_then_hold: level=%0d, required 14", level);
        end
        btn_up = 1'b1; btn_down = 1'b1;
        cyc(8);
        btn_up = 1'b0; btn_down = 1'b0;
        cyc(8);
        checks++;
        if (level !== 4'd14) begin
            errors++;
            $display("FAIL both_buttons: level=%0d, required 14", level);
        end
    endtask

    task automatic test_reset_mid_ramp;
        logic [3:0] exp_lvl;
        logic       t;
        int         idx;
        manual_level = 4'd0;
        mode = 2'b01;
        cyc(10);
        for (int c = 0; c < 8 && step_tick !== 1'b1; c++)
            cyc(1);
        checks++;
        if (level === 4'd0 || step_tick !== 1'b1) begin
            errors++;
            $display("FAIL ramp_before_reset: level=%0d tick=%b, required nonzero/1", level, step_tick);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (level !== 4'd0 || step_tick !== 1'b0 || level_changed !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: level=%0d tick=%b changed=%b, required 0/0/0", level, step_tick, level_changed);
        end
        cyc(2);
        rst_n = 1'b1;
        exp_lvl = 4'd0; idx = 1;
        for (int c = 0; c < 16 && idx <= 2; c++) begin
            t = step_tick;
            cyc(1);
            if (t) begin
                exp_lvl = 4'(idx);
                idx++;
            end
            checks++;
            if (level !== exp_lvl) begin
                errors++;
                $display("FAIL post_reset_breathe: level=%0d, required %0d", level, exp_lvl);
            end
        end
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL post_reset_ticks: ticks=%0d, required 2", idx - 1);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_breathe();
        test_sawtooth();
        test_step_buttons();
        test_bounce_and_both();
        test_reset_mid_ramp();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
